// File: rtl/vector_gather_map_if.sv
// rtl/vector_gather_map_if.sv - command, memory-write and output-row bundle for vector_gather_map
interface vector_gather_map_if #(
    parameter int N_OUT      = 8,
    parameter int UNITS      = 8,
    parameter int ELEM_W     = 32,
    parameter int IDX_W      = 32,
    parameter int MAX_CHUNKS = 4,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(MAX_CHUNKS) + 1
);
    logic                              wr_en;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [UNITS*ELEM_W-1:0]           wr_data;
    logic                              start;
    logic [CNT_W-1:0]                  num_chunks;
    logic [MAX_CHUNKS*N_OUT*IDX_W-1:0] idx_vec;
    logic                              out_ready;
    logic                              busy;
    logic                              out_valid;
    logic [N_OUT*ELEM_W-1:0]           out_row;
    logic [CNT_W-1:0]                  out_chunk;
    logic                              out_last;
    logic                              done;

    modport master (
        output wr_en, wr_addr, wr_data, start, num_chunks, idx_vec, out_ready,
        input  busy, out_valid, out_row, out_chunk, out_last, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, num_chunks, idx_vec, out_ready,
        output busy, out_valid, out_row, out_chunk, out_last, done
    );
endinterface

// File: rtl/vector_gather_map.sv
// rtl/vector_gather_map.sv - chunked gather of dense-vector elements by column index
// Three-stage decode / memory-read / lane-select pipeline under a single stall signal.
module vector_gather_map #(
    parameter int               N_OUT       = 8,
    parameter int               UNITS       = 8,
    parameter int               ELEM_W      = 32,
    parameter int               IDX_W       = 32,
    parameter int               MAX_CHUNKS  = 4,
    parameter int               DEPTH       = 1024,
    parameter int               ADDR_W      = $clog2(DEPTH),
    parameter int               CNT_W       = $clog2(MAX_CHUNKS) + 1,
    parameter logic [IDX_W-1:0] INVALID_IDX = 32'h00FFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    vector_gather_map_if.slave  bus
);
    localparam int SHIFT  = $clog2(UNITS);
    localparam int LANE_W = (UNITS > 1) ? SHIFT : 1;
    localparam int WORD_W = UNITS * ELEM_W;
    localparam int IDXV_W = MAX_CHUNKS * N_OUT * IDX_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [IDXV_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d, issue_q, issue_d;
    logic                         done_q, done_d;
    logic [CNT_W-1:0]             eff_cnt, issue_sel;
    logic                         advance, issue_fire, issue_last;

    logic                         d_valid_q, d_valid_d, d_last_q, d_last_d;
    logic [CNT_W-1:0]             d_chunk_q, d_chunk_d;
    logic [N_OUT-1:0][ADDR_W-1:0] d_word_q, d_word_d;
    logic [N_OUT-1:0][LANE_W-1:0] d_lane_q, d_lane_d;
    logic [N_OUT-1:0]             d_inv_q, d_inv_d;

    logic                         m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [CNT_W-1:0]             m_chunk_q, m_chunk_d;
    logic [N_OUT-1:0][LANE_W-1:0] m_lane_q, m_lane_d;
    logic [N_OUT-1:0]             m_inv_q, m_inv_d;
    logic [N_OUT-1:0][WORD_W-1:0] m_data_q, m_data_d;

    logic                         out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [CNT_W-1:0]             out_chunk_q, out_chunk_d;
    logic [N_OUT*ELEM_W-1:0]      out_row_q, out_row_d;

    logic [WORD_W-1:0]            mem [DEPTH];

    assign advance       = !(out_valid_q && !bus.out_ready);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_chunk = out_chunk_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;

    always_comb begin
        eff_cnt = bus.num_chunks;
        if (bus.num_chunks == '0)
            eff_cnt = CNT_W'(1);
        else if (bus.num_chunks > CNT_W'(MAX_CHUNKS))
            eff_cnt = CNT_W'(MAX_CHUNKS);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        issue_d    = issue_q;
        done_d     = 1'b0;
        issue_fire = 1'b0;
        issue_last = (issue_q == cnt_q - CNT_W'(1));
        case (state_q)
            IDLE: if (bus.start) begin
                idx_d   = bus.idx_vec;
                cnt_d   = eff_cnt;
                issue_d = '0;
                state_d = ISSUE;
            end
            ISSUE: if (advance) begin
                issue_fire = 1'b1;
                issue_d    = issue_q + CNT_W'(1);
                if (issue_last) state_d = DRAIN;
            end
            DRAIN: if (out_valid_q && bus.out_ready && out_last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode stage; the select is forced to chunk 0 when idle so the slice stays in range.
    always_comb begin : decode
        logic [IDX_W-1:0] idx_e;
        logic [IDX_W-1:0] word_e;
        idx_e     = '0;
        word_e    = '0;
        issue_sel = issue_fire ? issue_q : '0;
        d_valid_d = d_valid_q;
        d_last_d  = d_last_q;
        d_chunk_d = d_chunk_q;
        d_word_d  = d_word_q;
        d_lane_d  = d_lane_q;
        d_inv_d   = d_inv_q;
        if (advance) begin
            d_valid_d = issue_fire;
            d_last_d  = issue_last;
            d_chunk_d = issue_q;
            for (int j = 0; j < N_OUT; j++) begin
                idx_e       = idx_q[(int'(issue_sel) * N_OUT + j) * IDX_W +: IDX_W];
                word_e      = idx_e >> SHIFT;
                d_word_d[j] = word_e[ADDR_W-1:0];
                d_lane_d[j] = idx_e[LANE_W-1:0];
                d_inv_d[j]  = (idx_e == INVALID_IDX) || (word_e >= IDX_W'(DEPTH));
            end
        end
    end

    // Memory read register holds under stall like the other stages; reads are read-first.
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_chunk_d = m_chunk_q;
        m_lane_d  = m_lane_q;
        m_inv_d   = m_inv_q;
        m_data_d  = m_data_q;
        if (advance) begin
            m_valid_d = d_valid_q;
            m_last_d  = d_last_q;
            m_chunk_d = d_chunk_q;
            m_lane_d  = d_lane_q;
            m_inv_d   = d_inv_q;
            for (int j = 0; j < N_OUT; j++)
                m_data_d[j] = mem[d_word_q[j]];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_chunk_d = out_chunk_q;
        out_row_d   = out_row_q;
        if (advance) begin
            out_valid_d = m_valid_q;
            if (m_valid_q) begin
                out_last_d  = m_last_q;
                out_chunk_d = m_chunk_q;
                for (int j = 0; j < N_OUT; j++)
                    out_row_d[j*ELEM_W +: ELEM_W] = m_inv_q[j] ? '0 :
                        m_data_q[j][int'(m_lane_q[j]) * ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        m_data_q <= m_data_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            issue_q     <= '0;
            done_q      <= 1'b0;
            d_valid_q   <= 1'b0;
            d_last_q    <= 1'b0;
            d_chunk_q   <= '0;
            d_word_q    <= '0;
            d_lane_q    <= '0;
            d_inv_q     <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_chunk_q   <= '0;
            m_lane_q    <= '0;
            m_inv_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_chunk_q <= '0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            issue_q     <= issue_d;
            done_q      <= done_d;
            d_valid_q   <= d_valid_d;
            d_last_q    <= d_last_d;
            d_chunk_q   <= d_chunk_d;
            d_word_q    <= d_word_d;
            d_lane_q    <= d_lane_d;
            d_inv_q     <= d_inv_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_chunk_q   <= m_chunk_d;
            m_lane_q    <= m_lane_d;
            m_inv_q     <= m_inv_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_chunk_q <= out_chunk_d;
            out_row_q   <= out_row_d;
        end
    end
endmodule
